// File: rtl/arkhe_qmeasure_18b.sv
// arkhe_qmeasure_18b: single-qubit measurement/collapse stage.
// Squares the post-gate amplitudes into Born probabilities, draws a sample
// from a 16-bit LFSR weighted by those probabilities, and emits the measured
// bit, the collapsed basis state and a norm-drift flag.
module arkhe_qmeasure_18b #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [17:0] NORM_TOL  = 18'd64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [17:0] psi0_re_i,
  input  logic signed [17:0] psi0_im_i,
  input  logic signed [17:0] psi1_re_i,
  input  logic signed [17:0] psi1_im_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               meas_bit_o,
  output logic [17:0]        p0_o,
  output logic [17:0]        p1_o,
  output logic signed [17:0] col0_re_o,
  output logic signed [17:0] col0_im_o,
  output logic signed [17:0] col1_re_o,
  output logic signed [17:0] col1_im_o,
  output logic               norm_err_o,
  output logic [31:0]        meas_count_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SQUARE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [18:0] NORM_ONE = 19'd65536;
  localparam logic signed [17:0] AMP_ONE = 18'sd65536;

  logic [1:0]         state_q;
  logic signed [17:0] psi0_re_q, psi0_im_q, psi1_re_q, psi1_im_q;
  logic [17:0]        pr0_q, pr1_q;
  logic [18:0]        norm_q;
  logic [15:0]        lfsr_q;
  logic               out_valid_q, meas_bit_q, norm_err_q;
  logic [17:0]        p0_q, p1_q;
  logic signed [17:0] col0_re_q, col1_re_q;
  logic [31:0]        meas_count_q;

  logic [17:0] sq0_d, sq1_d;
  logic [15:0] lfsr_d;
  logic        meas_d, norm_err_d;
  logic [34:0] prod_d, thresh_d;
  logic [18:0] dev_d;

  // |re|^2 + |im|^2 in 2.16, scaled back from 4.32 and clamped to 18 bits.
  function automatic logic [17:0] born_prob(input logic signed [17:0] re,
                                            input logic signed [17:0] im);
    logic signed [36:0] re_x, im_x, sum, shifted;
    re_x    = 37'(re);
    im_x    = 37'(im);
    sum     = re_x * re_x + im_x * im_x;
    shifted = sum >>> 16;
    if (shifted > 37'sd262143) return 18'h3FFFF;
    else                       return shifted[17:0];
  endfunction

  // Probability squaring, weighted sample decision, norm check and LFSR step.
  always_comb begin
    sq0_d      = born_prob(psi0_re_q, psi0_im_q);
    sq1_d      = born_prob(psi1_re_q, psi1_im_q);
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Outcome 0 when rnd/2^16 < p0/norm, cross-multiplied to avoid a divider.
    prod_d     = 35'(lfsr_q) * 35'(norm_q);
    thresh_d   = {1'b0, pr0_q, 16'h0000};
    meas_d     = (norm_q != 19'd0) && !(prod_d < thresh_d);
    dev_d      = (norm_q >= NORM_ONE) ? (norm_q - NORM_ONE) : (NORM_ONE - norm_q);
    norm_err_d = (norm_q == 19'd0) || (dev_d > {1'b0, NORM_TOL});
  end

  // Pipeline FSM: capture, square, sample/collapse, then hold for handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      psi0_re_q    <= '0;
      psi0_im_q    <= '0;
      psi1_re_q    <= '0;
      psi1_im_q    <= '0;
      pr0_q        <= '0;
      pr1_q        <= '0;
      norm_q       <= '0;
      lfsr_q       <= SEED_EFF;
      out_valid_q  <= 1'b0;
      meas_bit_q   <= 1'b0;
      norm_err_q   <= 1'b0;
      p0_q         <= '0;
      p1_q         <= '0;
      col0_re_q    <= '0;
      col1_re_q    <= '0;
      meas_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            psi0_re_q <= psi0_re_i;
            psi0_im_q <= psi0_im_i;
            psi1_re_q <= psi1_re_i;
            psi1_im_q <= psi1_im_i;
            state_q   <= S_SQUARE;
          end
        end
        S_SQUARE: begin
          pr0_q   <= sq0_d;
          pr1_q   <= sq1_d;
          norm_q  <= {1'b0, sq0_d} + {1'b0, sq1_d};
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          meas_bit_q  <= meas_d;
          p0_q        <= pr0_q;
          p1_q        <= pr1_q;
          norm_err_q  <= norm_err_d;
          col0_re_q   <= meas_d ? 18'sd0 : AMP_ONE;
          col1_re_q   <= meas_d ? AMP_ONE : 18'sd0;
          out_valid_q <= 1'b1;
          lfsr_q      <= lfsr_d;
          state_q     <= S_HOLD;
        end
        default: begin
          if (out_ready_i) begin
            out_valid_q  <= 1'b0;
            meas_count_q <= meas_count_q + 32'd1;
            state_q      <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready_o   = (state_q == S_IDLE);
  assign out_valid_o  = out_valid_q;
  assign meas_bit_o   = meas_bit_q;
  assign p0_o         = p0_q;
  assign p1_o         = p1_q;
  assign col0_re_o    = col0_re_q;
  assign col0_im_o    = 18'sd0;
  assign col1_re_o    = col1_re_q;
  assign col1_im_o    = 18'sd0;
  assign norm_err_o   = norm_err_q;
  assign meas_count_o = meas_count_q;

endmodule
